// File: rtl/alu_pkg.sv
// Shared types for the arbitrated 4-bit logic unit: opcode and FSM encodings, data width.
package alu_pkg;
  localparam int DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_SHL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_logic_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one response consumer.
interface alu_logic_arbiter_if #(parameter int CNT_W = 8) ();
  import alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  data_t            req0_a;
  data_t            req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  data_t            req1_a;
  data_t            req1_b;
  logic [2:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  data_t            rsp_result;
  logic             rsp_zero;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, busy, done_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, busy, done_cnt
  );
endinterface

// File: rtl/ALU_Logic.sv
// Purely combinational 4-bit logic unit; every operation is produced in parallel,
// the caller selects one.
module ALU_Logic
  import alu_pkg::*;
(
  input  data_t a,
  input  data_t b,
  output data_t and_r,
  output data_t nand_r,
  output data_t or_r,
  output data_t nor_r,
  output data_t xor_r,
  output data_t xnor_r,
  output data_t nota_r,
  output data_t shl_r
);
  assign and_r  = a & b;
  assign nand_r = ~(a & b);
  assign or_r   = a | b;
  assign nor_r  = ~(a | b);
  assign xor_r  = a ^ b;
  assign xnor_r = ~(a ^ b);
  assign nota_r = ~a;
  assign shl_r  = {a[DATA_W-2:0], 1'b0};
endmodule

// File: rtl/alu_logic_arbiter.sv
// Two-port round-robin front end to ALU_Logic: accept in IDLE, compute in EXEC, hold result in RESP.
// One op in flight; response held until rsp_ready, so peak rate is one op every 3 cycles.
module alu_logic_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_logic_arbiter_if.slave   bus
);
  state_e           state_q, state_d;
  logic             last_q;
  logic             winner;
  logic             grant0, grant1, accept, rsp_hs;
  data_t            a_q, b_q;
  op_e              op_q;
  logic             id_q;
  data_t            res_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;
  data_t            mux_res;
  data_t            and_r, nand_r, or_r, nor_r, xor_r, xnor_r, nota_r, shl_r;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    winner = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) winner = ~last_q;
  end

  assign grant0 = (state_q == IDLE) & bus.req0_valid & ~winner;
  assign grant1 = (state_q == IDLE) & bus.req1_valid & winner;
  assign accept = grant0 | grant1;
  assign rsp_hs = (state_q == RESP) & bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ALU_Logic u_alu (
    .a      (a_q),
    .b      (b_q),
    .and_r  (and_r),
    .nand_r (nand_r),
    .or_r   (or_r),
    .nor_r  (nor_r),
    .xor_r  (xor_r),
    .xnor_r (xnor_r),
    .nota_r (nota_r),
    .shl_r  (shl_r)
  );

  always_comb begin
    mux_res = '0;
    case (op_q)
      OP_AND:  mux_res = and_r;
      OP_NAND: mux_res = nand_r;
      OP_OR:   mux_res = or_r;
      OP_NOR:  mux_res = nor_r;
      OP_XOR:  mux_res = xor_r;
      OP_XNOR: mux_res = xnor_r;
      OP_NOTA: mux_res = nota_r;
      OP_SHL:  mux_res = shl_r;
      default: mux_res = '0;
    endcase
  end

  // Pointer resets to 1 so that requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      res_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        a_q    <= grant1 ? bus.req1_a : bus.req0_a;
        b_q    <= grant1 ? bus.req1_b : bus.req0_b;
        op_q   <= op_e'(grant1 ? bus.req1_op : bus.req0_op);
        id_q   <= grant1;
        last_q <= grant1;
      end
      if (state_q == EXEC) begin
        res_q  <= mux_res;
        zero_q <= (mux_res == '0);
      end
      if (rsp_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done_cnt   = cnt_q;
endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_alu_logic_arbiter;
  localparam int CW  = 2;
  localparam int MOD = 1 << CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  // Reference model: one pending op with its age in cycles since acceptance.
  logic       m_pend;
  int         m_age;
  logic       m_id;
  logic [3:0] m_res;
  logic       m_last;
  int         m_cnt;

  always #5 clk = ~clk;

  alu_logic_arbiter_if #(.CNT_W(CW)) bus ();
  alu_logic_arbiter #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a & b;
      1: r = 15 - (a & b);
      2: r = a | b;
      3: r = 15 - (a | b);
      4: r = a ^ b;
      5: r = 15 - (a ^ b);
      6: r = 15 - a;
      default: r = (a * 2) % 16;
    endcase
    return r[3:0];
  endfunction

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                       input logic rr);
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = o1;
    bus.rsp_ready  = rr;
    #1;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 4'h0, 4'h0, 3'd0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 4'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got=%b exp=0", bus.rsp_zero); end
    checks++; if (bus.done_cnt !== CW'(0)) begin errors++; $display("FAIL reset_done_cnt got=%0d exp=0", bus.done_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 4'hC, 4'hA, 3'd0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_exec valid/busy got=%b%b exp=01", bus.rsp_valid, bus.busy); end
    idle(1'b1);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_result !== 4'h8 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0) begin
      errors++; $display("FAIL single_rsp got res=%h id=%b zero=%b exp res=8 id=0 zero=0", bus.rsp_result, bus.rsp_id, bus.rsp_zero); end
    exp_cnt = (exp_cnt + 1) % MOD;
    idle(1'b0);
    checks++; if (bus.busy !== 1'b0 || bus.done_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL single_done got busy=%b cnt=%0d exp busy=0 cnt=%0d", bus.busy, bus.done_cnt, exp_cnt); end
  endtask

  task automatic test_tie();
    do_reset();
    drive(1'b1, 4'h5, 4'h5, 3'd4, 1'b1, 4'h3, 4'h4, 3'd2, 1'b0);
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL tie_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    drive(1'b1, 4'h5, 4'h5, 3'd4, 1'b1, 4'h3, 4'h4, 3'd2, 1'b0);
    drive(1'b1, 4'h5, 4'h5, 3'd4, 1'b1, 4'h3, 4'h4, 3'd2, 1'b1);
    checks++; if (bus.rsp_result !== 4'h0 || bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b0) begin
      errors++; $display("FAIL tie_rsp0 got res=%h zero=%b id=%b exp res=0 zero=1 id=0", bus.rsp_result, bus.rsp_zero, bus.rsp_id); end
    exp_cnt = (exp_cnt + 1) % MOD;
    drive(1'b1, 4'h5, 4'h5, 3'd4, 1'b1, 4'h3, 4'h4, 3'd2, 1'b0);
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin errors++; $display("FAIL tie_second_grant got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
    idle(1'b0);
    idle(1'b1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h7 || bus.rsp_id !== 1'b1 || bus.rsp_zero !== 1'b0) begin
      errors++; $display("FAIL tie_rsp1 got v=%b res=%h id=%b zero=%b exp v=1 res=7 id=1 zero=0", bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_zero); end
    exp_cnt = (exp_cnt + 1) % MOD;
    idle(1'b0);
    checks++; if (bus.done_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL tie_done_cnt got=%0d exp=%0d", bus.done_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 4'h6, 4'h3, 3'd4, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0);
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h5 || bus.rsp_id !== 1'b1 || bus.rsp_zero !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b res=%h id=%b zero=%b exp v=1 res=5 id=1 zero=0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_zero); end
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1 || bus.done_cnt !== CW'(exp_cnt)) begin
        errors++; $display("FAIL stall_side[%0d] got rdy=%b%b busy=%b cnt=%0d exp rdy=00 busy=1 cnt=%0d", i, bus.req0_ready, bus.req1_ready, bus.busy, bus.done_cnt, exp_cnt); end
    end
    drive(1'b1, 4'h1, 4'h1, 3'd0, 1'b1, 4'h2, 4'h2, 3'd0, 1'b1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release got v=%b rdy=%b%b exp v=1 rdy=00", bus.rsp_valid, bus.req0_ready, bus.req1_ready); end
    exp_cnt = (exp_cnt + 1) % MOD;
    idle(1'b0);
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.done_cnt !== CW'(exp_cnt)) begin
      errors++; $display("FAIL stall_idle got busy=%b v=%b cnt=%0d exp busy=0 v=0 cnt=%0d", bus.busy, bus.rsp_valid, bus.done_cnt, exp_cnt); end
  endtask

  task automatic test_ops();
    logic [2:0] ops [3] = '{3'd7, 3'd6, 3'd3};
    logic [3:0] as  [3] = '{4'h9, 4'hF, 4'h0};
    logic [3:0] bs  [3] = '{4'h5, 4'h3, 4'h0};
    logic [3:0] res [3] = '{4'h2, 4'h0, 4'hF};
    logic       zs  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, as[i], bs[i], ops[i], 1'b0, 4'h0, 4'h0, 3'd0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res[i] || bus.rsp_zero !== zs[i]) begin
        errors++; $display("FAIL ops[%0d] got v=%b res=%h zero=%b exp v=1 res=%h zero=%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, res[i], zs[i]); end
      exp_cnt = (exp_cnt + 1) % MOD;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'h5, 4'h6, 3'd5, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL areset_accept got=%b exp=1", bus.req0_ready); end
    idle(1'b1);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 4'h0 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0 || bus.done_cnt !== CW'(0)) begin
      errors++; $display("FAIL areset_outputs got busy=%b v=%b res=%h zero=%b id=%b cnt=%0d exp all 0", bus.busy, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_id, bus.done_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done_cnt !== CW'(0)) begin
        errors++; $display("FAIL areset_no_rsp[%0d] got v=%b busy=%b cnt=%0d exp 0 0 0", i, bus.rsp_valid, bus.busy, bus.done_cnt); end
    end
    drive(1'b1, 4'h3, 4'h3, 3'd0, 1'b1, 4'h1, 4'h1, 3'd0, 1'b0);
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL areset_tie got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    idle(1'b0);
    idle(1'b1);
    checks++; if (bus.rsp_result !== 4'h3 || bus.rsp_id !== 1'b0) begin errors++; $display("FAIL areset_rsp got res=%h id=%b exp res=3 id=0", bus.rsp_result, bus.rsp_id); end
    exp_cnt = (exp_cnt + 1) % MOD;
  endtask

  task automatic test_wrap_alternate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h1, 4'h2, 3'd2, 1'b1, 4'h4, 4'h8, 3'd2, 1'b1);
      checks++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL alt_grant[%0d] got=%b%b exp id %0d", i, bus.req0_ready, bus.req1_ready, i % 2); end
      drive(1'b1, 4'h1, 4'h2, 3'd2, 1'b1, 4'h4, 4'h8, 3'd2, 1'b1);
      drive(1'b1, 4'h1, 4'h2, 3'd2, 1'b1, 4'h4, 4'h8, 3'd2, 1'b1);
      checks++; if (bus.rsp_id !== 1'(i % 2) || bus.rsp_result !== ((i % 2 == 0) ? 4'h3 : 4'hC)) begin
        errors++; $display("FAIL alt_rsp[%0d] got id=%b res=%h exp id=%0d", i, bus.rsp_id, bus.rsp_result, i % 2); end
    end
    idle(1'b0);
    checks++; if (bus.done_cnt !== CW'(0) || bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_cnt got cnt=%0d busy=%b exp cnt=0 busy=0", bus.done_cnt, bus.busy); end
  endtask

  task automatic test_random();
    logic v0, v1, rr, w, e_r0, e_r1, e_rv;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] o0, o1;
    do_reset();
    m_pend = 1'b0; m_age = 0; m_id = 1'b0; m_res = 4'h0; m_last = 1'b1; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 2) != 0); v1 = ($urandom_range(0, 2) != 0); rr = ($urandom_range(0, 2) != 0);
      a0 = 4'($urandom); b0 = 4'($urandom); o0 = 3'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); o1 = 3'($urandom);
      drive(v0, a0, b0, o0, v1, a1, b1, o1, rr);
      w    = (v0 && v1) ? !m_last : v1;
      e_r0 = !m_pend && v0 && !w;
      e_r1 = !m_pend && v1 && w;
      e_rv = m_pend && (m_age >= 2);
      checks++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) begin
        errors++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready, e_r0, e_r1); end
      checks++; if (bus.rsp_valid !== e_rv || bus.busy !== m_pend || bus.done_cnt !== CW'(m_cnt)) begin
        errors++; $display("FAIL rand_status c=%0d got v=%b busy=%b cnt=%0d exp v=%b busy=%b cnt=%0d", c, bus.rsp_valid, bus.busy, bus.done_cnt, e_rv, m_pend, m_cnt); end
      if (e_rv) begin
        checks++; if (bus.rsp_id !== m_id || bus.rsp_result !== m_res || bus.rsp_zero !== (m_res == 4'h0)) begin
          errors++; $display("FAIL rand_rsp c=%0d got id=%b res=%h zero=%b exp id=%b res=%h", c, bus.rsp_id, bus.rsp_result, bus.rsp_zero, m_id, m_res); end
      end
      if (e_rv && rr) begin
        m_pend = 1'b0; m_cnt = (m_cnt + 1) % MOD;
      end else if (m_pend) begin
        m_age++;
      end else if (e_r0 || e_r1) begin
        m_pend = 1'b1; m_age = 1; m_id = e_r1; m_last = e_r1;
        m_res  = e_r1 ? ref_alu(int'(a1), int'(b1), int'(o1)) : ref_alu(int'(a0), int'(b0), int'(o0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_ops();
    test_async_reset();
    test_wrap_alternate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
